// File: rtl/bomb_scheduler.sv
// Bomb drop scheduler: qualifies and arbitrates player drop requests, presents accepted bombs
// until bombTick consumes them, and tracks live bombs per player. Macro BOMB_SCHED_STATS_EN adds reject counters.
module bomb_scheduler #(
    parameter int unsigned MAX_BOMBS      = 2,
    parameter int unsigned FUSE_TICKS     = 3,
    parameter int unsigned COOLDOWN_TICKS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bombTick,
    input  logic [1:0]   game_state,
    input  logic [99:0]  i_curBombMap_0,
    input  logic [99:0]  i_curBombMap_1,
    input  logic         reqA,
    input  logic         reqB,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    output logic         bombA_v,
    output logic         bombB_v,
    output logic [3:0]   bombA_x,
    output logic [3:0]   bombA_y,
    output logic [3:0]   bombB_x,
    output logic [3:0]   bombB_y,
    output logic         ackA,
    output logic         ackB,
`ifdef BOMB_SCHED_STATS_EN
    output logic [7:0]   dropA,
    output logic [7:0]   dropB,
`endif
    output logic [2:0]   liveA,
    output logic [2:0]   liveB
);

    localparam int unsigned NP = 2;
    localparam int unsigned CW = 3;
    localparam logic [CW-1:0] MAX_L  = CW'(MAX_BOMBS);
    localparam logic [CW-1:0] FUSE_L = CW'(FUSE_TICKS);
    localparam logic [CW-1:0] COOL_L = CW'(COOLDOWN_TICKS);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t        state_q [NP];
    state_t        state_d [NP];
    logic          req_q   [NP];
    logic [CW-1:0] slot_q  [NP][MAX_BOMBS];
    logic [CW-1:0] slot_d  [NP][MAX_BOMBS];
    logic [CW-1:0] cool_q  [NP];
    logic [CW-1:0] cool_d  [NP];
    logic [CW-1:0] live_q  [NP];
    logic [CW-1:0] live_d  [NP];
    logic [3:0]    x_q     [NP];
    logic [3:0]    x_d     [NP];
    logic [3:0]    y_q     [NP];
    logic [3:0]    y_d     [NP];
    logic          ack_q   [NP];
    logic          ack_d   [NP];
    logic          v_q     [NP];
    logic          v_d     [NP];
    logic          ptr_q;
    logic          ptr_d;

    logic          req_c   [NP];
    logic [3:0]    px_c    [NP];
    logic [3:0]    py_c    [NP];
    logic [6:0]    idx_c   [NP];
    logic          rise_c  [NP];
    logic          qual_c  [NP];
    logic          win_c   [NP];
    logic          placed_c;

    // Request qualification and same-cell arbitration (ptr_q: 0 = A has priority)
    always_comb begin
        req_c[0] = reqA;
        req_c[1] = reqB;
        px_c[0]  = playerAx;
        py_c[0]  = playerAy;
        px_c[1]  = playerBx;
        py_c[1]  = playerBy;
        ptr_d    = ptr_q;
        for (int p = 0; p < 2; p++) begin
            rise_c[p] = req_c[p] & ~req_q[p];
            idx_c[p]  = 7'(px_c[p]) * 7'd10 + 7'(py_c[p]);
            qual_c[p] = rise_c[p]
                     && (game_state == 2'd0)
                     && (state_q[p] == IDLE)
                     && (live_q[p] < MAX_L)
                     && (cool_q[p] == '0)
                     && (px_c[p] >= 4'd1) && (px_c[p] <= 4'd8)
                     && (py_c[p] >= 4'd1) && (py_c[p] <= 4'd8)
                     && !i_curBombMap_1[idx_c[p]] && !i_curBombMap_0[idx_c[p]]
                     && !(v_q[1-p] && (x_q[1-p] == px_c[p]) && (y_q[1-p] == py_c[p]));
            win_c[p]  = qual_c[p];
        end
        if (qual_c[0] && qual_c[1] && (px_c[0] == px_c[1]) && (py_c[0] == py_c[1])) begin
            if (ptr_q) win_c[0] = 1'b0;
            else       win_c[1] = 1'b0;
            ptr_d = ~ptr_q;
        end
    end

    // Per-player FSM, fuse slots and cooldown; slots age before a new bomb is loaded
    always_comb begin
        placed_c = 1'b0;
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            x_d[p]     = x_q[p];
            y_d[p]     = y_q[p];
            ack_d[p]   = 1'b0;
            cool_d[p]  = cool_q[p];
            placed_c   = 1'b0;
            for (int s = 0; s < int'(MAX_BOMBS); s++) slot_d[p][s] = slot_q[p][s];

            if (bombTick) begin
                if (cool_q[p] != '0) cool_d[p] = cool_q[p] - 3'd1;
                for (int s = 0; s < int'(MAX_BOMBS); s++)
                    if (slot_q[p][s] != '0) slot_d[p][s] = slot_q[p][s] - 3'd1;
            end

            case (state_q[p])
                IDLE: begin
                    if (win_c[p]) begin
                        state_d[p] = PENDING;
                        x_d[p]     = px_c[p];
                        y_d[p]     = py_c[p];
                        ack_d[p]   = 1'b1;
                    end
                end
                PENDING: begin
                    if (game_state != 2'd0) begin
                        state_d[p] = IDLE;
                    end else if (bombTick) begin
                        state_d[p] = IDLE;
                        cool_d[p]  = COOL_L;
                        for (int s = 0; s < int'(MAX_BOMBS); s++) begin
                            if (!placed_c && (slot_d[p][s] == '0)) begin
                                slot_d[p][s] = FUSE_L;
                                placed_c     = 1'b1;
                            end
                        end
                    end
                end
                default: state_d[p] = IDLE;
            endcase

            live_d[p] = '0;
            for (int s = 0; s < int'(MAX_BOMBS); s++)
                if (slot_d[p][s] != '0) live_d[p] = live_d[p] + 3'd1;
            v_d[p] = (state_d[p] == PENDING);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= IDLE;
                req_q[p]   <= 1'b0;
                cool_q[p]  <= '0;
                live_q[p]  <= '0;
                x_q[p]     <= '0;
                y_q[p]     <= '0;
                ack_q[p]   <= 1'b0;
                v_q[p]     <= 1'b0;
                for (int s = 0; s < int'(MAX_BOMBS); s++) slot_q[p][s] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                req_q[p]   <= req_c[p];
                cool_q[p]  <= cool_d[p];
                live_q[p]  <= live_d[p];
                x_q[p]     <= x_d[p];
                y_q[p]     <= y_d[p];
                ack_q[p]   <= ack_d[p];
                v_q[p]     <= v_d[p];
                for (int s = 0; s < int'(MAX_BOMBS); s++) slot_q[p][s] <= slot_d[p][s];
            end
        end
    end

`ifdef BOMB_SCHED_STATS_EN
    logic [7:0] drop_q [NP];

    // Saturating count of rejected request edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) drop_q[p] <= '0;
        end else begin
            for (int p = 0; p < 2; p++)
                if (rise_c[p] && !win_c[p] && (drop_q[p] != 8'hFF)) drop_q[p] <= drop_q[p] + 8'd1;
        end
    end

    assign dropA = drop_q[0];
    assign dropB = drop_q[1];
`endif

    assign bombA_v = v_q[0];
    assign bombB_v = v_q[1];
    assign bombA_x = x_q[0];
    assign bombA_y = y_q[0];
    assign bombB_x = x_q[1];
    assign bombB_y = y_q[1];
    assign ackA    = ack_q[0];
    assign ackB    = ack_q[1];
    assign liveA   = live_q[0];
    assign liveB   = live_q[1];

endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
Sits between the player input logic and the bomb map updater, on the fast system clock. Each player raises a drop request. The block qualifies the request against occupancy, per-player bomb limit, cooldown and game state. It arbitrates same-cell conflicts and holds accepted bombs as bombA_*/bombB_* presentations until the bomb clock consumes them. It also tracks each player's live bombs until their fuse expires.

Parameters:
MAX_BOMBS, 2, maximum live bombs per player (1..4)
FUSE_TICKS, 3, bomb ticks from consumption until the bomb no longer counts as live (1..7)
COOLDOWN_TICKS, 1, bomb ticks after consumption before the same player may be accepted again (0..7)

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-low
bombTick  in  1  one-clk pulse, the first clk cycle after each bombClk rising edge
game_state  in  2  0 = playing, nonzero = game over
i_curBombMap_0  in  100  bomb map bit 0, cell index 10*x+y
i_curBombMap_1  in  100  bomb map bit 1
reqA, reqB  in  1  drop request, level; edge-detected internally
playerAx, playerAy, playerBx, playerBy  in  4  player coordinates
bombA_v, bombB_v  out  1  bomb presented to updater
bombA_x, bombA_y, bombB_x, bombB_y  out  4  presented cell
ackA, ackB  out  1  one-clk pulse, request accepted
liveA, liveB  out  3  live bomb count per player

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, pending and fuse slots cleared, cooldowns 0, priority pointer = A.
- Request edge: a 0->1 transition of reqX, registered; level held high does not re-request.
- Accept conditions for player X on its request edge, all required:
  - game_state == 0
  - no pending bomb for X
  - liveX < MAX_BOMBS
  - cooldownX == 0
  - coordinates in 1..8
  - map cell {map_1,map_0} == 00
  - cell differs from the other player's pending cell
- On accept: latch coordinates, set bombX_v = 1 next cycle, pulse ackX for that same cycle.
- Reject: silently drop the request; no ack.
- Same-cycle edges from both players on the same cell: the priority pointer's player wins. The pointer then flips to the other player. The loser is rejected.
- Different cells in the same cycle: both are accepted.
- Per-player state machine:
  - IDLE -> PENDING on accept.
  - PENDING -> IDLE on bombTick.
  - On that same bombTick: bombX_v drops next cycle, a free fuse slot loads FUSE_TICKS, cooldownX loads COOLDOWN_TICKS.
- Coordinates remain stable while v = 1; x/y keep their last value after v drops.
- Each bombTick decrements every nonzero fuse slot and cooldown.
- A slot reaching 0 frees itself. liveX = number of nonzero slots.
- Decrement and load in the same tick: existing slots decrement first; the new slot loads the full FUSE_TICKS.
- Request edge in the same cycle as bombTick for a pending player: rejected, because the player is still PENDING.
- game_state becomes nonzero:
  - pending bombs are cleared next cycle and v is deasserted
  - fuse slots and cooldowns keep counting
  - no new accepts
- Reset mid-PENDING: the bomb is discarded and never presented.

Optional Feature:
BOMB_SCHED_STATS_EN
- Defined: adds outputs dropA, dropB (8-bit each), counting rejected request edges per player. They saturate at 255 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then reqA edge with A at (3,4) on an empty map -> ackA pulse. Next cycle bombA_v=1, x=3, y=4. bombTick -> v=0, liveA=1.
- A and B both at (5,5) with edges in the same cycle after reset -> only ackA fires. Repeat after both consume and recover -> only ackB fires.
- MAX_BOMBS=2: A places three bombs across ticks -> third rejected while liveA=2. After FUSE_TICKS=3 ticks from the first consumption -> liveA=1 and the next request is accepted.
- reqA held high across 10 cycles -> exactly one ackA. Map cell (2,2) = 01 and A at (2,2) -> rejected. A at (0,4) -> rejected.
- A pending and game_state set to 2 -> bombA_v=0 next cycle; a subsequent reqA edge gives no ack.
- rst asserted asynchronously mid-PENDING -> bombA_v=0 immediately; no presentation after rst is released.
